// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_FAST_PATH_EN to finish divide-by-zero and signed overflow in one cycle.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] dividend;
    logic [4:0]      rd_q;
    logic            op_rem;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic            special;

    logic            in_signed;
    logic            in_zero;
    logic            in_ovf;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;
    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] final_result;

    // Architected results for divide-by-zero and most-negative / -1.
    function automatic logic [XLEN-1:0] special_value(input logic is_rem, input logic zero,
                                                      input logic [XLEN-1:0] dvd);
        if (zero)
            special_value = is_rem ? dvd : '1;
        else
            special_value = is_rem ? '0 : MIN_NEG;
    endfunction

    always_comb begin
        in_signed = ~op[0];
        in_zero   = (rs2_val == '0);
        in_ovf    = in_signed && (rs1_val == MIN_NEG) && (rs2_val == '1);
        a_abs     = (in_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
        b_abs     = (in_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
    end

    // One restoring step; the extra top bit of trial is the borrow that rejects the subtract.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {2'b00, divisor};
        if (!trial[XLEN+1]) begin
            rem_nxt = trial[XLEN:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[XLEN:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end
        q_fix = neg_q ? -quo_nxt : quo_nxt;
        r_fix = neg_r ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
        if (special)
            final_result = special_value(op_rem, div_zero, dividend);
        else
            final_result = op_rem ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            dividend <= '0;
            rd_q     <= '0;
            op_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            special  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            rd_out   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        op_rem   <= op[1];
                        rd_q     <= rd_in;
                        dividend <= rs1_val;
                        quo      <= a_abs;
                        divisor  <= b_abs;
                        rem      <= '0;
                        neg_q    <= in_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                        neg_r    <= in_signed && rs1_val[XLEN-1];
                        div_zero <= in_zero;
                        special  <= in_zero || in_ovf;
                        count    <= CW'(XLEN);
                        busy     <= 1'b1;
`ifdef DIV_FAST_PATH_EN
                        if (in_zero || in_ovf) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= special_value(op[1], in_zero, rs1_val);
                            rd_out <= rd_in;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem   <= rem_nxt;
                        quo   <= quo_nxt;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= final_result;
                            rd_out <= rd_q;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model plus directed literal checks.
module tb_div_unit;

    localparam int XLEN = 32;
`ifdef DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int SPECIAL_LAT = FAST ? 1 : XLEN + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            kill = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] rs1_val = '0;
    logic [XLEN-1:0] rs2_val = '0;
    logic [4:0]      rd_in = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    int total = 0;
    int bad = 0;
    int cycles = 0;
    bit chk_en = 1'b0;

    // Reference model state.
    logic            m_busy = 1'b0;
    logic            m_done = 1'b0;
    int              m_left = 0;
    logic [XLEN-1:0] m_pend_res = '0;
    logic [4:0]      m_pend_rd = '0;
    logic [XLEN-1:0] m_result = '0;
    logic [4:0]      m_rd = '0;

    div_unit #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .kill    (kill),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    always #5 clk = ~clk;

    function automatic bit is_special(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        is_special = (b == '0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RV32M results straight from the ISA definition.
    function automatic logic [XLEN-1:0] model_div(input logic [1:0] o, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0)
            model_div = o[1] ? a : 32'hFFFF_FFFF;
        else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            model_div = o[1] ? 32'h0 : 32'h8000_0000;
        else begin
            case (o)
                2'b00:   model_div = sa / sb;
                2'b01:   model_div = a / b;
                2'b10:   model_div = sa % sb;
                default: model_div = a % b;
            endcase
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_left   <= 0;
            m_result <= '0;
            m_rd     <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_done) begin
                m_busy <= 1'b0;
            end else if (m_busy) begin
                if (kill) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_done   <= 1'b1;
                    m_result <= m_pend_res;
                    m_rd     <= m_pend_rd;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !kill) begin
                m_busy     <= 1'b1;
                m_pend_res <= model_div(op, rs1_val, rs2_val);
                m_pend_rd  <= rd_in;
                if (FAST && is_special(op, rs1_val, rs2_val)) begin
                    m_done   <= 1'b1;
                    m_result <= model_div(op, rs1_val, rs2_val);
                    m_rd     <= rd_in;
                end else begin
                    m_left <= XLEN;
                end
            end
        end
    end

    task automatic checkVal(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkVal("model busy", {31'b0, busy}, {31'b0, m_busy});
            checkVal("model done", {31'b0, done}, {31'b0, m_done});
            checkVal("model result", result, m_result);
            checkVal("model rd_out", {27'b0, rd_out}, {27'b0, m_rd});
        end
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [4:0] r);
        @(negedge clk);
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_in   = r;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        op      = 2'b11;
        rs1_val = 32'hDEAD_BEEF;
        rs2_val = 32'h0000_0003;
        rd_in   = 5'd31;
        cycles  = 1;
    endtask

    task automatic checkOutput(input string name, input logic [XLEN-1:0] exp_res,
                               input logic [4:0] exp_rd, input int exp_lat);
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: done timeout after %0d cycles, required latency %0d", name, cycles, exp_lat);
        end else begin
            checkVal({name, " latency"}, cycles, exp_lat);
            checkVal({name, " result"}, result, exp_res);
            checkVal({name, " rd"}, {27'b0, rd_out}, {27'b0, exp_rd});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkVal("reset busy", {31'b0, busy}, 32'd0);
        checkVal("reset done", {31'b0, done}, 32'd0);
        checkVal("reset result", result, 32'd0);
        checkVal("reset rd", {27'b0, rd_out}, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        applyStimulus(2'b01, 32'd100, 32'd7, 5'd5);
        checkOutput("divu 100/7", 32'd14, 5'd5, 33);
        applyStimulus(2'b11, 32'd100, 32'd7, 5'd6);
        checkOutput("remu 100/7", 32'd2, 5'd6, 33);
        applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7);
        checkOutput("div -7/2", 32'hFFFF_FFFD, 5'd7, 33);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8);
        checkOutput("rem -7/2", 32'hFFFF_FFFF, 5'd8, 33);
        applyStimulus(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd11);
        checkOutput("div 7/-2", 32'hFFFF_FFFD, 5'd11, 33);
        applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd12);
        checkOutput("rem 7/-2", 32'd1, 5'd12, 33);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd13);
        checkOutput("divu max/1", 32'hFFFF_FFFF, 5'd13, 33);
        applyStimulus(2'b00, 32'd1234, 32'd0, 5'd1);
        checkOutput("div by zero", 32'hFFFF_FFFF, 5'd1, SPECIAL_LAT);
        applyStimulus(2'b10, 32'd1234, 32'd0, 5'd2);
        checkOutput("rem by zero", 32'd1234, 5'd2, SPECIAL_LAT);
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
        checkOutput("div overflow", 32'h8000_0000, 5'd3, SPECIAL_LAT);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        checkOutput("rem overflow", 32'd0, 5'd4, SPECIAL_LAT);

        // Start pulses while busy and during the done cycle must be ignored.
        applyStimulus(2'b01, 32'd1000, 32'd10, 5'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cycles++;
            op = 2'b01; rs1_val = 32'd9; rs2_val = 32'd3; rd_in = 5'd20; start = 1'b1;
            @(negedge clk);
            cycles++;
            start = 1'b0;
        end
        checkOutput("divu 1000/10", 32'd100, 5'd10, 33);
        op = 2'b01; rs1_val = 32'd9; rs2_val = 32'd3; rd_in = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkVal("start in done busy", {31'b0, busy}, 32'd0);

        // Kill mid-CALC, then kill+start in IDLE, then a clean relaunch.
        applyStimulus(2'b01, 32'd1000, 32'd3, 5'd9);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkVal("kill busy", {31'b0, busy}, 32'd0);
        checkVal("kill result", result, 32'd100);
        checkVal("kill rd", {27'b0, rd_out}, 32'd10);
        op = 2'b01; rs1_val = 32'd8; rs2_val = 32'd2; rd_in = 5'd22; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        checkVal("kill+start busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        applyStimulus(2'b01, 32'd50, 32'd5, 5'd14);
        checkOutput("divu 50/5", 32'd10, 5'd14, 33);

        // Reset in the middle of an iteration.
        applyStimulus(2'b01, 32'd100, 32'd7, 5'd15);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkVal("midreset busy", {31'b0, busy}, 32'd0);
        checkVal("midreset done", {31'b0, done}, 32'd0);
        checkVal("midreset result", result, 32'd0);
        checkVal("midreset rd", {27'b0, rd_out}, 32'd0);
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M divide ops: DIV, DIVU, REM and REMU.
- Sits directly downstream of the register file. Consumes the two read-port values (rs1/rs2) and returns a quotient or remainder plus destination index.
- The result feeds the register-file write port, and done serves as that port's write enable.
- The control unit stalls the core while busy is high.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- kill  input  1  synchronous flush of the in-flight op
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- rs1_val  input  XLEN  dividend (register-file read port 1)
- rs2_val  input  XLEN  divisor (register-file read port 2)
- rd_in  input  5  destination register index
- busy  output  1  op in flight (CALC or DONE state)
- done  output  1  one-cycle pulse; result and rd_out valid
- result  output  XLEN  quotient or remainder
- rd_out  output  5  latched destination index

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state=IDLE, busy=0, done=0, result=0, rd_out=0, all internal registers cleared. Reset has priority over kill, start and iteration.
- FSM states:
  - IDLE: on start, latch op, rd_in, |rs1|, |rs2| (absolute values for signed ops, raw for unsigned), sign flags and special-case flags. Clear the XLEN+1-bit partial remainder. Set count=XLEN. Go to CALC.
  - CALC: per cycle, shift {rem, quo} left 1; trial = rem - divisor. If non-negative, rem=trial and quotient LSB=1. Decrement count; go to DONE when count reaches 0.
  - DONE: done=1 for exactly one cycle; result and rd_out registered here; go to IDLE.
- Latency: done high exactly XLEN+1 cycles after the edge that sampled start (33 for XLEN=32). busy high for the same span, and is 0 again on the cycle after done.
- start while busy: ignored, with no effect on the in-flight op. start in the DONE cycle is also ignored. Earliest new launch is in the first IDLE cycle after done.
- Sign correction:
  - Quotient negated when operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- Special cases, always applied in the result mux:
  - Divisor=0: DIV/DIVU -> all ones; REM/REMU -> rs1_val unchanged.
  - Signed overflow (DIV/REM, rs1=0x8000_0000, rs2=0xFFFF_FFFF): DIV -> 0x8000_0000; REM -> 0.
- result and rd_out hold their last value between done pulses.
- kill: in CALC or DONE, return to IDLE on the next edge. No done pulse, result and rd_out unchanged, busy=0 the following cycle. In IDLE, kill is a no-op. If kill and start are both high in IDLE, kill wins and nothing launches.
- Operands are latched at start. Changes on rs1_val, rs2_val, rd_in and op afterwards have no effect.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined: divide-by-zero and signed-overflow cases skip CALC and go IDLE -> DONE directly. done is high on the cycle right after the start edge (latency 1); result values are as listed above.
- Undefined: all ops take the full XLEN+1 latency, with the same result values via the result mux.

Test Plan:
- DIVU rs1=100, rs2=7, rd_in=5 -> done exactly 33 cycles after start, result=14, rd_out=5. REMU with the same operands -> result=2.
- DIV rs1=-7 (0xFFFF_FFF9), rs2=2 -> result=0xFFFF_FFFD (-3). REM with the same operands -> result=0xFFFF_FFFF (-1).
- Divide by zero:
  - DIV 1234/0 -> result=0xFFFF_FFFF.
  - REM 1234/0 -> result=1234.
  - Latency is 33 without the macro, 1 with it.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF -> result=0x8000_0000. REM with the same operands -> result=0.
- Kill and restart:
  - kill at cycle 10 of CALC -> no done, busy=0 next cycle, result unchanged.
  - Then start DIVU 50/5 -> result=10 after 33 cycles.
  - Start pulses issued during busy have no effect.
- Reset asserted mid-CALC -> next cycle busy=0, done=0, result=0, rd_out=0. No done pulse follows.
